// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the mux select arbiter: FSM state encoding, select
// width, channel count, default grant timeout and hold-counter width.
package mux_pkg;

  localparam int SEL_W           = 2;
  localparam int NCH             = 4;
  localparam int TIMEOUT_DEFAULT = 8;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin pick for the mux select arbiter.
// Ports:
//   req    in  NCH    per-channel request
//   last   in  SEL_W  last granted channel; search starts at last+1
//   winner out SEL_W  first requesting channel found searching upward mod NCH
//   any    out 1      at least one request is present
module rr_pick
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  assign any = |req;

  // Offsets 1..NCH cover every channel once, ending back at last itself,
  // so a lone request on the previously granted channel still wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Round-robin arbiter that drives the select of a downstream 4-to-1 mux.
// A grant holds sel/valid until the consumer acks, the request is withdrawn,
// or TIMEOUT cycles pass (forced release, one-cycle timeout_err pulse).
// Every grant is followed by a single RELEASE cycle before re-arbitration.
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   req          in   NCH    per-channel request
//   ack          in   1      consumer took the data (sampled in GRANT only)
//   sel          out  SEL_W  registered mux select
//   valid        out  1      registered; sel stable, mux output meaningful
//   timeout_err  out  1      registered one-cycle pulse on forced release
//   busy         out  1      state is not IDLE
module mux_sel_arbiter #(
  parameter int TIMEOUT = mux_pkg::TIMEOUT_DEFAULT,
  parameter int NCH     = mux_pkg::NCH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic                     ack,
  output logic [mux_pkg::SEL_W-1:0] sel,
  output logic                     valid,
  output logic                     timeout_err,
  output logic                     busy
);

  import mux_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] winner;
  logic             any;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      // Last = 3 so the first search after reset starts at channel 0.
      last        <= SEL_W'(NCH - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (any) begin
            state <= ST_GRANT;
            sel   <= winner;
            valid <= 1'b1;
          end else begin
            valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Ack beats withdrawal beats timeout; only the timeout path flags.
          if (ack) begin
            state <= ST_RELEASE;
            valid <= 1'b0;
            last  <= sel;
          end else if (!req[sel]) begin
            state <= ST_RELEASE;
            valid <= 1'b0;
            last  <= sel;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_RELEASE;
            valid       <= 1'b0;
            last        <= sel;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter. Each scenario task pushes the
// channel it expects to be granted into a scoreboard queue; a monitor pops
// and compares on every new grant (valid rising). Tasks also check the
// cycle-level behaviour inline.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic       valid;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic       valid_q = 1'b0;

  mux_sel_arbiter #(.TIMEOUT(8), .NCH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .sel         (sel),
    .valid       (valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: one pop per grant, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid === 1'b1 && valid_q === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_grant: got sel=%0d, expected no grant", sel);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (sel !== e) begin
          errors++;
          $display("FAIL sb_grant_sel: got sel=%0d, expected %0d", sel, e);
        end
      end
    end
    valid_q <= valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clean reset pulse placed just after a rising edge.
  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;
    step();
    step();
    checks++; if (sel !== 2'd0)         begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req = 4'b0001;
    exp_q.push_back(2'd0);
    step();  // edge 1
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_e1: got %b want 1", valid); end
    checks++; if (sel !== 2'd0)   begin errors++; $display("FAIL basic_sel_e1: got %0d want 0", sel); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL basic_busy_e1: got %b want 1", busy); end
    step();  // edge 2
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_e2: got %b want 1", valid); end
    ack = 1'b1;
    step();  // edge 3
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e3: got %b want 0", valid); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL basic_busy_e3: got %b want 1", busy); end
    ack = 1'b0;
    req = 4'b0000;
    step();  // edge 4
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_busy_e4: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(seq[k]);
    for (int k = 0; k < 5; k++) begin
      step();  // grant edge
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", k, valid); end
      checks++; if (sel !== seq[k]) begin errors++; $display("FAIL rr_sel[%0d]: got %0d want %0d", k, sel, seq[k]); end
      ack = 1'b1;
      step();  // ack edge -> RELEASE
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL rr_release[%0d]: got valid=%b busy=%b want valid=0 busy=1", k, valid, busy);
      end
      ack = 1'b0;
      if (k == 4) req = 4'b0000;
      step();  // RELEASE -> IDLE
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got busy=%b want 0", k, busy); end
    end
  endtask

  task automatic test_timeout();
    int hi;
    int pulses;
    req = 4'b0100;
    ack = 1'b0;
    exp_q.push_back(2'd2);
    step();  // grant edge
    hi = (valid === 1'b1) ? 1 : 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (timeout_err === 1'b1) pulses++;
      if (valid !== 1'b1) break;
      step();
      if (valid === 1'b1) hi++;
    end
    checks++; if (hi != 8)              begin errors++; $display("FAIL to_valid_cycles: got %0d want 8", hi); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b want 1", timeout_err); end
    req = 4'b0000;
    step();
    if (timeout_err === 1'b1) pulses++;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_width: got %b want 0", timeout_err); end
    checks++; if (pulses != 1)          begin errors++; $display("FAIL to_err_count: got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL to_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_withdraw();
    // last = 2 here, so a lone request on channel 1 wins.
    req = 4'b0010;
    exp_q.push_back(2'd1);
    step();  // grant edge, cycle 1 of GRANT follows
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL wd_sel: got %0d want 1", sel); end
    step();  // cycle 2 of GRANT
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wd_hold: got %b want 1", valid); end
    req = 4'b0000;
    step();  // withdrawal seen -> RELEASE
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wd_release: got valid=%b busy=%b want valid=0 busy=1", valid, busy);
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_no_err: got %b want 0", timeout_err); end
    // Search resumes at channel 2: {0,2} requesting -> 2.
    req = 4'b0101;
    exp_q.push_back(2'd2);
    step();  // RELEASE -> IDLE
    step();  // grant
    checks++; if (sel !== 2'd2 || valid !== 1'b1) begin
      errors++; $display("FAIL wd_next: got sel=%0d valid=%b want sel=2 valid=1", sel, valid);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0100;
    exp_q.push_back(2'd2);
    step();
    checks++; if (sel !== 2'd2 || valid !== 1'b1) begin
      errors++; $display("FAIL rg_grant: got sel=%0d valid=%b want sel=2 valid=1", sel, valid);
    end
    step();
    rst = 1'b1;
    #1;
    checks++; if (sel !== 2'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL rg_async: got sel=%0d valid=%b want sel=0 valid=0", sel, valid);
    end
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rg_async_flags: got err=%b busy=%b want 0 0", timeout_err, busy);
    end
    #1 rst = 1'b0;
    req = 4'b0110;
    exp_q.push_back(2'd1);
    step();
    checks++; if (sel !== 2'd1 || valid !== 1'b1) begin
      errors++; $display("FAIL rg_post: got sel=%0d valid=%b want sel=1 valid=1", sel, valid);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 4'b0000;
    step();
  endtask

  task automatic test_ack_at_timeout();
    // last = 1 here: search 2,3,0 -> channel 0.
    req = 4'b0001;
    exp_q.push_back(2'd0);
    step();  // grant, counter 0
    for (int i = 0; i < 7; i++) step();  // counter reaches TIMEOUT-1
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL at_hold: got %b want 1", valid); end
    ack = 1'b1;
    step();
    checks++; if (valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL at_release: got valid=%b err=%b want 0 0", valid, timeout_err);
    end
    ack = 1'b0;
    req = 4'b0000;
    step();
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL at_idle: got err=%b busy=%b want 0 0", timeout_err, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_reset_mid_grant();
    test_ack_at_timeout();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending grants, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
